// File: rtl/fft_seq_ctrl_if.sv
// Beat handshake and datapath control bundle for the pipelined FFT sequencer.
// master = upstream/datapath side, slave = the controller.
interface fft_seq_ctrl_if #(
    parameter int unsigned AW = 5
) ();
    logic          in_valid;
    logic          in_sof;
    logic          flush;
    logic          in_ready;
    logic          adv;
    logic          zero_fill;
    logic [AW-1:0] coeff0_addr;
    logic [AW-1:0] coeff1_addr;
    logic          stage1_en;
    logic          bfii_ctrl;
    logic          out_valid;
    logic          out_sof;
    logic          busy;
    logic          sof_err;

    modport master (
        output in_valid, in_sof, flush,
        input  in_ready, adv, zero_fill, coeff0_addr, coeff1_addr,
               stage1_en, bfii_ctrl, out_valid, out_sof, busy, sof_err
    );

    modport slave (
        input  in_valid, in_sof, flush,
        output in_ready, adv, zero_fill, coeff0_addr, coeff1_addr,
               stage1_en, bfii_ctrl, out_valid, out_sof, busy, sof_err
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for the 2-lane pipelined FFT: advance enable, twiddle
// addressing, BFII switching, zero-pad/drain and frame-aligned output valid.
module fft_seq_ctrl #(
    parameter int unsigned N     = 32,
    parameter int unsigned DELAY = 16,
    parameter int unsigned PIPE  = 1,
    parameter int unsigned AW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    fft_seq_ctrl_if.slave bus
);

    localparam int unsigned FB  = N / 4;
    localparam int unsigned LAT = DELAY + PIPE;
    localparam int unsigned CW  = (FB > 1) ? $clog2(FB) : 1;
    localparam int unsigned ACW = $clog2(LAT + 1);
    localparam int unsigned SW  = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int unsigned DW  = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [CW-1:0]  CNT_LAST = CW'(FB - 1);
    localparam logic [ACW-1:0] LAT_C    = ACW'(LAT);
    localparam logic [ACW-1:0] S1_ON    = ACW'(DELAY - 1);
    localparam logic [SW-1:0]  S1_LAST  = SW'(DELAY - 1);
    localparam logic [DW-1:0]  DRN_LAST = DW'(LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        PAD,
        DRAIN
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  in_cnt_q, in_cnt_d;
    logic [CW-1:0]  out_cnt_q, out_cnt_d;
    logic [ACW-1:0] adv_cnt_q, adv_cnt_d;
    logic [SW-1:0]  s1_cnt_q, s1_cnt_d;
    logic [CW-1:0]  c1_cnt_q, c1_cnt_d;
    logic [DW-1:0]  drn_cnt_q, drn_cnt_d;
    logic           stage1_en_q, stage1_en_d;
    logic           bfii_q, bfii_d;
    logic           sof_err_q, sof_err_d;

    logic adv;
    logic in_ready;
    logic zero_fill;
    logic busy;
    logic out_valid;
    logic out_sof;
    logic framed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            adv_cnt_q   <= '0;
            s1_cnt_q    <= '0;
            c1_cnt_q    <= '0;
            drn_cnt_q   <= '0;
            stage1_en_q <= 1'b0;
            bfii_q      <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            adv_cnt_q   <= adv_cnt_d;
            s1_cnt_q    <= s1_cnt_d;
            c1_cnt_q    <= c1_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            stage1_en_q <= stage1_en_d;
            bfii_q      <= bfii_d;
            sof_err_q   <= sof_err_d;
        end
    end

    // Next state and counters; every counter moves only on an advancing cycle.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        adv_cnt_d   = adv_cnt_q;
        s1_cnt_d    = s1_cnt_q;
        c1_cnt_d    = c1_cnt_q;
        drn_cnt_d   = drn_cnt_q;
        stage1_en_d = stage1_en_q;
        bfii_d      = bfii_q;
        sof_err_d   = sof_err_q;
        framed      = (state_q == FILL) || (state_q == RUN);

        if (adv) begin
            if (adv_cnt_q != LAT_C) begin
                adv_cnt_d = adv_cnt_q + 1'b1;
            end
            if (state_q != DRAIN) begin
                in_cnt_d = (in_cnt_q == CNT_LAST) ? '0 : in_cnt_q + 1'b1;
            end
            if (stage1_en_q) begin
                s1_cnt_d = (s1_cnt_q == S1_LAST) ? '0 : s1_cnt_q + 1'b1;
                c1_cnt_d = (c1_cnt_q == CNT_LAST) ? '0 : c1_cnt_q + 1'b1;
                if (s1_cnt_q == S1_LAST) begin
                    bfii_d = ~bfii_q;
                end
            end else if (adv_cnt_q == S1_ON) begin
                // Stage-1 data arrives here; the switch flips into its first half-period.
                stage1_en_d = 1'b1;
                bfii_d      = 1'b1;
            end
            if (out_valid) begin
                out_cnt_d = (out_cnt_q == CNT_LAST) ? '0 : out_cnt_q + 1'b1;
            end
        end

        if (framed && adv && (bus.in_sof != (in_cnt_q == '0))) begin
            sof_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (adv) begin
                    state_d = (adv_cnt_d == LAT_C) ? RUN : FILL;
                end
            end
            FILL, RUN: begin
                if (bus.flush) begin
                    state_d = ((in_cnt_q == '0) && !adv) ? DRAIN : PAD;
                end else if (adv_cnt_d == LAT_C) begin
                    state_d = RUN;
                end
            end
            PAD: begin
                if (in_cnt_q == CNT_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drn_cnt_d = drn_cnt_q + 1'b1;
                if (drn_cnt_q == DRN_LAST) begin
                    state_d     = IDLE;
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    adv_cnt_d   = '0;
                    s1_cnt_d    = '0;
                    c1_cnt_d    = '0;
                    drn_cnt_d   = '0;
                    stage1_en_d = 1'b0;
                    bfii_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // adv is gated by rst so a sof beat presented during reset cannot advance.
    always_comb begin
        adv       = 1'b0;
        in_ready  = 1'b0;
        zero_fill = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                adv      = rst & bus.in_valid & bus.in_sof;
            end
            FILL, RUN: begin
                in_ready = 1'b1;
                adv      = bus.in_valid;
            end
            PAD, DRAIN: begin
                adv       = 1'b1;
                zero_fill = 1'b1;
            end
            default: ;
        endcase
        busy      = (state_q != IDLE);
        out_valid = adv & busy & (adv_cnt_q >= LAT_C);
        out_sof   = out_valid & (out_cnt_q == '0);
    end

    assign bus.in_ready    = in_ready;
    assign bus.adv         = adv;
    assign bus.zero_fill   = zero_fill;
    assign bus.coeff0_addr = AW'(in_cnt_q);
    assign bus.coeff1_addr = AW'(c1_cnt_q);
    assign bus.stage1_en   = stage1_en_q;
    assign bus.bfii_ctrl   = bfii_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_sof     = out_sof;
    assign bus.busy        = busy;
    assign bus.sof_err     = sof_err_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a frame-level reference model.
module tb_fft_seq_ctrl;

    localparam int N     = 32;
    localparam int FB    = 8;
    localparam int DELAY = 16;
    localparam int LAT   = 17;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fft_seq_ctrl_if #(.AW(AW)) bus ();

    fft_seq_ctrl #(
        .N(N),
        .DELAY(DELAY),
        .PIPE(1),
        .AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 accepting, 2 padding, 3 draining.
    int m_mode, m_n, m_k, m_pad, m_drn;
    bit m_err;

    logic          s_adv, s_rdy, s_zf, s_s1, s_bf, s_ov, s_osof, s_busy, s_err;
    logic [AW-1:0] s_c0, s_c1;

    typedef struct {
        bit v, s, f;
        bit adv, busy, rdy, zf;
        int c0;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_k = 0; m_pad = 0; m_drn = 0; m_err = 1'b0;
    endtask

    task automatic reset_vals_check();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_adv", 32'(bus.adv), 32'd0);
        chk("rst_zero_fill", 32'(bus.zero_fill), 32'd0);
        chk("rst_coeff0", 32'(bus.coeff0_addr), 32'd0);
        chk("rst_coeff1", 32'(bus.coeff1_addr), 32'd0);
        chk("rst_stage1_en", 32'(bus.stage1_en), 32'd0);
        chk("rst_bfii", 32'(bus.bfii_ctrl), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sof", 32'(bus.out_sof), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sof_err", 32'(bus.sof_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.in_sof   = 1'($urandom);
            bus.flush    = 1'($urandom);
            #1;
            reset_vals_check();
        end
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.flush    = 1'b0;
    endtask

    // One clock: drive, sample and compare against the model, then step the model.
    task automatic cycle(input bit v, input bit s, input bit f);
        bit e_adv, e_rdy, e_zf, e_busy, e_s1, e_bf, e_ov, e_osof, acc;
        int e_c0, e_c1;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.flush    = f;
        #1;
        s_adv = bus.adv;  s_rdy = bus.in_ready; s_zf = bus.zero_fill;
        s_s1 = bus.stage1_en; s_bf = bus.bfii_ctrl; s_ov = bus.out_valid;
        s_osof = bus.out_sof; s_busy = bus.busy; s_err = bus.sof_err;
        s_c0 = bus.coeff0_addr; s_c1 = bus.coeff1_addr;

        e_adv  = (m_mode == 0) ? (v & s) : (m_mode == 1) ? v : 1'b1;
        e_rdy  = (m_mode <= 1);
        e_zf   = (m_mode >= 2);
        e_busy = (m_mode != 0);
        e_s1   = (m_n >= DELAY);
        e_c0   = m_k % FB;
        e_c1   = e_s1 ? (m_n - DELAY) % FB : 0;
        e_bf   = e_s1 && ((((m_n - DELAY) / DELAY) % 2) == 0);
        e_ov   = e_adv && e_busy && (m_n >= LAT);
        e_osof = e_ov && (((m_n - LAT) % FB) == 0);

        chk("adv", 32'(s_adv), 32'(e_adv));
        chk("in_ready", 32'(s_rdy), 32'(e_rdy));
        chk("zero_fill", 32'(s_zf), 32'(e_zf));
        chk("busy", 32'(s_busy), 32'(e_busy));
        chk("coeff0_addr", 32'(s_c0), e_c0);
        chk("coeff1_addr", 32'(s_c1), e_c1);
        chk("stage1_en", 32'(s_s1), 32'(e_s1));
        chk("bfii_ctrl", 32'(s_bf), 32'(e_bf));
        chk("out_valid", 32'(s_ov), 32'(e_ov));
        chk("out_sof", 32'(s_osof), 32'(e_osof));
        chk("sof_err", 32'(s_err), 32'(m_err));

        @(posedge clk);
        case (m_mode)
            0: if (e_adv) begin m_mode = 1; m_n = 1; m_k = 1; end
            1: begin
                acc = v;
                if (acc) begin
                    if (((m_k % FB) == 0) != s) m_err = 1'b1;
                    m_n++; m_k++;
                end
                if (f) begin
                    if (!acc && (m_k % FB) == 0) begin m_mode = 3; m_drn = LAT; end
                    else begin m_mode = 2; m_pad = FB - (m_k % FB); end
                end
            end
            2: begin
                m_n++; m_k++; m_pad--;
                if (m_pad == 0) begin m_mode = 3; m_drn = LAT; end
            end
            default: begin
                m_n++; m_drn--;
                if (m_drn == 0) begin m_mode = 0; m_n = 0; m_k = 0; end
            end
        endcase
    endtask

    // Expectations for the N=32 stream, indexed by advance number from sof.
    task automatic adv_checks(input int a);
        chk($sformatf("coeff0@%0d", a), 32'(s_c0), (a < 32) ? a % 8 : 0);
        chk($sformatf("stage1_en@%0d", a), 32'(s_s1), 32'(a >= 16));
        if (a == 16) chk("coeff1@16", 32'(s_c1), 32'd0);
        chk($sformatf("bfii@%0d", a), 32'(s_bf), 32'((a >= 16 && a < 32) || a >= 48));
        chk($sformatf("out_valid@%0d", a), 32'(s_ov), 32'(a >= 17));
        chk($sformatf("out_sof@%0d", a), 32'(s_osof), 32'(a == 17 || a == 25 || a == 33 || a == 41));
        chk($sformatf("sof_err@%0d", a), 32'(s_err), 32'd0);
    endtask

    task automatic run_stream(input bit gaps);
        do_reset();
        for (int a = 0; a < 32; a++) begin
            cycle(1'b1, (a % 8) == 0, 1'b0);
            adv_checks(a);
            if (gaps) begin
                cycle(1'b0, 1'b0, 1'b0);
                chk("gap_adv", 32'(s_adv), 32'd0);
                chk("gap_coeff0", 32'(s_c0), (a + 1) % 8);
                chk("gap_out_valid", 32'(s_ov), 32'd0);
            end
        end
        cycle(1'b0, 1'b0, 1'b1);
        chk("flush_at0_adv", 32'(s_adv), 32'd0);
        for (int a = 32; a < 49; a++) begin
            cycle(1'b0, 1'b0, 1'b0);
            adv_checks(a);
            chk("drain_zero_fill", 32'(s_zf), 32'd1);
        end
        cycle(1'b0, 1'b0, 1'b0);
        chk("stream_end_busy", 32'(s_busy), 32'd0);
        chk("stream_end_stage1", 32'(s_s1), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int  dcnt;
        bit  done;
        bit  v, s, f;

        //           v     s     f     adv   busy  rdy   zf    c0
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7};

        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.flush    = 1'b0;
        model_reset();

        // Discarded beats in IDLE, sof start, stall, flush at in_cnt=3, padding.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].f);
            chk($sformatf("tbl%0d_adv", i), 32'(s_adv), 32'(tbl[i].adv));
            chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_in_ready", i), 32'(s_rdy), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_zero_fill", i), 32'(s_zf), 32'(tbl[i].zf));
            chk($sformatf("tbl%0d_coeff0", i), 32'(s_c0), tbl[i].c0);
        end

        // Drain with sof held high: not taken until the controller is back in IDLE.
        dcnt = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (!s_busy) begin
                done = 1'b1;
                chk("idle_stage1_en", 32'(s_s1), 32'd0);
            end else if (s_zf && !s_rdy) begin
                dcnt++;
            end
        end
        chk("drain_done", 32'(done), 32'd1);
        chk("drain_cycles", 32'(dcnt), 32'd17);
        cycle(1'b0, 1'b0, 1'b0);
        chk("resof_busy", 32'(s_busy), 32'd1);
        chk("resof_coeff0", 32'(s_c0), 32'd1);

        run_stream(1'b0);
        run_stream(1'b1);

        // Misplaced sof in RUN, sticky error, then asynchronous reset mid-frame.
        do_reset();
        for (int a = 0; a < 21; a++) cycle(1'b1, (a % 8) == 0, 1'b0);
        chk("err_before", 32'(s_err), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            chk("err_sticky", 32'(s_err), 32'd1);
        end
        #3;
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b1;
        rst = 1'b0;
        #1;
        reset_vals_check();
        do_reset();

        // Randomized traffic with occasional bad framing and flushes.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 99) < 75);
            s = ((m_k % FB) == 0);
            if ($urandom_range(0, 99) < 3) s = !s;
            f = ($urandom_range(0, 99) < 2);
            cycle(v, s, f);
            if ((i % 750) == 749) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Sequencing controller for the 2-lane parallel pipelined FFT datapath (BF stage, twiddle multipliers, BFII delay blocks, stage-2 multipliers, output saturators). It accepts a beat-level input handshake and produces the datapath advance enable, the per-stage twiddle ROM addresses, the BFII switch control, the stage-1 coefficient enable, and frame-aligned output valid/start-of-frame. It also zero-pads and drains the pipeline on request.

## Interface
- N, 32: FFT points; power of 2, ≥ 8. FB = N/4 beats per frame (2 lanes × up/down).
- DELAY, 16: BFII delay-block depth in advances.
- PIPE, 1: register stages after the delay blocks. LAT = DELAY + PIPE.
- AW, $clog2(N): twiddle address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  the input beat (4 samples) is present.
- in_sof  in  1  the beat is the first beat of a frame.
- flush  in  1  request to finish the current frame and drain the pipeline.
- in_ready  out  1  the controller accepts input.
- adv  out  1  datapath advance/clock-enable for the current cycle.
- zero_fill  out  1  the datapath substitutes zeros for the input this beat.
- coeff0_addr  out  AW  stage-0 twiddle index.
- coeff1_addr  out  AW  stage-1 twiddle index.
- stage1_en  out  1  stage-1 coefficient ROMs active.
- bfii_ctrl  out  1  BFII delay-block switch select.
- out_valid  out  1  the datapath output is a valid beat.
- out_sof  out  1  the output beat is the first of a frame.
- busy  out  1  state is not IDLE.
- sof_err  out  1  sticky framing error.

## Operation
- States: IDLE, FILL, RUN, PAD, DRAIN. Reset enters IDLE.
- Counters:
  - in_cnt: 0..FB-1, wraps.
  - out_cnt: 0..FB-1, wraps.
  - adv_cnt: 0..LAT, saturating.
  - s1_cnt: 0..DELAY-1, wraps.
- IDLE:
  - in_ready=1.
  - adv = in_valid & in_sof. Beats without in_sof are discarded (adv=0).
  - A beat with sof advances: in_cnt←1, adv_cnt←1, then the state goes to FILL.
- FILL/RUN:
  - in_ready=1; adv = in_valid.
  - Each advance increments in_cnt and adv_cnt.
  - FILL→RUN when adv_cnt reaches LAT.
- Framing check in FILL/RUN:
  - in_sof on an accepted beat with in_cnt≠0 sets sof_err.
  - An accepted beat at in_cnt=0 without in_sof also sets sof_err.
  - There is no resync; sof_err clears only on reset.
- flush: sampled in FILL/RUN on any cycle.
  - If in_cnt=0 with no beat accepted that cycle, the next state is DRAIN.
  - Otherwise the next state is PAD. The flush cycle's own beat, if valid, is still accepted.
- PAD:
  - in_ready=0, adv=1, zero_fill=1 every cycle.
  - Pads the remaining FB−in_cnt beats, then goes to DRAIN.
- DRAIN:
  - in_ready=0, adv=1, zero_fill=1.
  - Runs exactly LAT cycles, then goes to IDLE. All counters clear on entering IDLE.
  - A flush during PAD/DRAIN is ignored.
- coeff0_addr = in_cnt (zero-extended), the index of the current beat.
- stage1_en:
  - Set on the advance that brings the total advance count since sof to DELAY.
  - Stays 1 until IDLE.
- s1_cnt and bfii_ctrl:
  - s1_cnt counts advances while stage1_en=1.
  - bfii_ctrl starts at 0 and toggles each time s1_cnt wraps, i.e. every DELAY advances.
- coeff1_addr = beat index of the stage-1 data = (advance count − DELAY) mod FB, held at 0 while stage1_en=0.
- out_valid:
  - out_valid = adv & (adv_cnt ≥ LAT) in FILL/RUN/PAD/DRAIN, so it is 0 in IDLE.
  - In DRAIN it is also asserted while draining.
- out_sof = out_valid & (out_cnt=0). out_cnt increments on each out_valid.

## Timing
- Reset values (while rst=0):
  - state IDLE; in_ready=1.
  - All other outputs 0: adv, zero_fill, coeff0_addr, coeff1_addr, stage1_en, bfii_ctrl, out_valid, out_sof, busy, sof_err.
- rst assertion clears state asynchronously, mid-frame included. Outputs take reset values in the same cycle.
- adv, in_ready, zero_fill, out_valid and out_sof are combinational from state/counters and in_valid.
- All counters update on the edge of an advancing cycle. Nothing changes when adv=0 (stall-safe).
- Latency: accepted beat k (counting from sof = beat 0) appears at the output with out_valid on advance k+LAT.
- A new in_sof in the same cycle as the DRAIN→IDLE transition is not accepted (in_ready=0). It is accepted on the following cycle.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs → in_ready=1, every other output 0, busy=0.
- Continuous stream (N=32, FB=8, DELAY=16, PIPE=1), 4 frames, sof every 8 beats:
  - coeff0_addr cycles 0..7.
  - stage1_en rises after advance 16, with coeff1_addr=0 on advance 16.
  - bfii_ctrl toggles at advances 16, 32, 48.
  - First out_valid/out_sof on advance 17; out_sof again at advances 25, 33 and 41.
  - sof_err stays 0.
- in_valid every other cycle: adv=0 on the gaps and all counters/addresses hold. The output sequence matches the continuous case counted in advances.
- IDLE with 3 beats without sof, then a sof beat → adv=0 for the 3 beats; in_cnt=1 and busy=1 after the sof beat.
- flush on the edge that accepts beat in_cnt=3:
  - 4 PAD cycles (zero_fill=1, in_ready=0), then 17 DRAIN cycles.
  - Then IDLE: busy=0 and stage1_en=0.
- In RUN, a sof at in_cnt=5 → sof_err=1 and it stays 1. Then async rst=0 mid-RUN → immediate reset values, including sof_err=0.
